// File: rtl/fib_wb_checker.sv
// Register-writeback checker: snoops register file writes to one watched GPR and
// compares them against an internally generated Fibonacci sequence.
module fib_wb_checker #(
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         WATCH_REG   = 9,
  parameter int unsigned         NUM_TERMS   = 10,
  parameter logic [DATA_W-1:0]   FIB0        = '0,
  parameter logic [DATA_W-1:0]   FIB1        = DATA_W'(1),
  parameter int unsigned         TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [7:0]        term_count,
  output logic [7:0]        mismatch_count,
  output logic [7:0]        first_bad_idx,
  output logic [DATA_W-1:0] first_bad_data,
  output logic [DATA_W-1:0] last_data
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        LAST_TERM = 8'(NUM_TERMS - 1);
  localparam logic              TO_EN     = (TIMEOUT_CYC != 0);
  localparam logic              WATCH_EN  = (WATCH_REG != 0);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t              r_state, w_state;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_pass, w_pass;
  logic                r_timeout, w_timeout;
  logic [7:0]          r_term_count, w_term_count;
  logic [7:0]          r_mismatch_count, w_mismatch_count;
  logic [7:0]          r_first_bad_idx, w_first_bad_idx;
  logic [DATA_W-1:0]   r_first_bad_data, w_first_bad_data;
  logic [DATA_W-1:0]   r_last_data, w_last_data;
  logic [DATA_W-1:0]   r_exp_a, w_exp_a;
  logic [DATA_W-1:0]   r_exp_b, w_exp_b;
  logic [IDLE_W-1:0]   r_idle_cnt, w_idle_cnt;
  logic                w_hit;

  assign w_hit = WATCH_EN && wb_en && (wb_addr == 5'(WATCH_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_term_count     <= '0;
      r_mismatch_count <= '0;
      r_first_bad_idx  <= '0;
      r_first_bad_data <= '0;
      r_last_data      <= '0;
      r_exp_a          <= FIB0;
      r_exp_b          <= FIB1;
      r_idle_cnt       <= '0;
    end else begin
      r_state          <= w_state;
      r_busy           <= w_busy;
      r_done           <= w_done;
      r_pass           <= w_pass;
      r_timeout        <= w_timeout;
      r_term_count     <= w_term_count;
      r_mismatch_count <= w_mismatch_count;
      r_first_bad_idx  <= w_first_bad_idx;
      r_first_bad_data <= w_first_bad_data;
      r_last_data      <= w_last_data;
      r_exp_a          <= w_exp_a;
      r_exp_b          <= w_exp_b;
      r_idle_cnt       <= w_idle_cnt;
    end
  end

  // Next-state and next-output logic; arm restarts from any state and beats a hit.
  always_comb begin
    w_state          = r_state;
    w_pass           = r_pass;
    w_timeout        = r_timeout;
    w_term_count     = r_term_count;
    w_mismatch_count = r_mismatch_count;
    w_first_bad_idx  = r_first_bad_idx;
    w_first_bad_data = r_first_bad_data;
    w_last_data      = r_last_data;
    w_exp_a          = r_exp_a;
    w_exp_b          = r_exp_b;
    w_idle_cnt       = r_idle_cnt;

    if (arm) begin
      w_state          = S_CHECK;
      w_pass           = 1'b0;
      w_timeout        = 1'b0;
      w_term_count     = '0;
      w_mismatch_count = '0;
      w_first_bad_idx  = '0;
      w_first_bad_data = '0;
      w_last_data      = '0;
      w_exp_a          = FIB0;
      w_exp_b          = FIB1;
      w_idle_cnt       = '0;
    end else begin
      case (r_state)
        S_CHECK: begin
          if (w_hit) begin
            w_term_count = r_term_count + 8'd1;
            w_last_data  = wb_data;
            w_idle_cnt   = '0;
            w_exp_a      = r_exp_b;
            w_exp_b      = r_exp_a + r_exp_b;
            if (wb_data != r_exp_a) begin
              if (r_mismatch_count != 8'hFF) w_mismatch_count = r_mismatch_count + 8'd1;
              if (r_mismatch_count == 8'd0) begin
                w_first_bad_idx  = r_term_count;
                w_first_bad_data = wb_data;
              end
            end
            if (r_term_count == LAST_TERM) begin
              w_state = S_DONE;
              w_pass  = (w_mismatch_count == 8'd0);
            end
          end else begin
            w_idle_cnt = r_idle_cnt + IDLE_W'(1);
            if (TO_EN && (r_idle_cnt == IDLE_LAST)) begin
              w_state   = S_DONE;
              w_timeout = 1'b1;
              w_pass    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    w_busy = (w_state == S_CHECK);
    w_done = (w_state == S_DONE);
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign term_count     = r_term_count;
  assign mismatch_count = r_mismatch_count;
  assign first_bad_idx  = r_first_bad_idx;
  assign first_bad_data = r_first_bad_data;
  assign last_data      = r_last_data;

endmodule

// File: tb/tb_fib_wb_checker.sv
// Directed bench for fib_wb_checker: default instance plus a wrap-around
// configuration (FIB0=FFFF_FFFF, FIB1=1, four terms).
module tb_fib_wb_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic        busy, done, pass, timeout;
  logic [7:0]  term_count, mismatch_count, first_bad_idx;
  logic [31:0] first_bad_data, last_data;

  logic        busy2, done2, pass2, timeout2;
  logic [7:0]  term_count2, mismatch_count2, first_bad_idx2;
  logic [31:0] first_bad_data2, last_data2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fib_wb_checker dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .term_count(term_count),
    .mismatch_count(mismatch_count), .first_bad_idx(first_bad_idx),
    .first_bad_data(first_bad_data), .last_data(last_data)
  );

  fib_wb_checker #(.FIB0(32'hFFFF_FFFF), .FIB1(32'd1), .NUM_TERMS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2), .term_count(term_count2),
    .mismatch_count(mismatch_count2), .first_bad_idx(first_bad_idx2),
    .first_bad_data(first_bad_data2), .last_data(last_data2)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_terms;
    logic [7:0]  exp_mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; returns #1 after the edge with inputs idle again.
  task automatic cyc(input logic a, input logic en, input logic [4:0] ad, input logic [31:0] d);
    @(negedge clk);
    arm = a; wb_en = en; wb_addr = ad; wb_data = d;
    @(posedge clk);
    #1;
    arm = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    cyc(1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  logic [31:0] fib [10];
  vec_t        vf  [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    fib = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    vf = '{
      '{1'b1, 5'd9, 32'd0,  8'd1,  8'd0}, '{1'b1, 5'd8, 32'd99, 8'd1,  8'd0},
      '{1'b1, 5'd9, 32'd1,  8'd2,  8'd0}, '{1'b1, 5'd0, 32'd99, 8'd2,  8'd0},
      '{1'b0, 5'd9, 32'd5,  8'd2,  8'd0}, '{1'b1, 5'd9, 32'd1,  8'd3,  8'd0},
      '{1'b1, 5'd9, 32'd2,  8'd4,  8'd0}, '{1'b1, 5'd8, 32'd99, 8'd4,  8'd0},
      '{1'b1, 5'd9, 32'd3,  8'd5,  8'd0}, '{1'b1, 5'd9, 32'd5,  8'd6,  8'd0},
      '{1'b0, 5'd9, 32'd77, 8'd6,  8'd0}, '{1'b1, 5'd9, 32'd8,  8'd7,  8'd0},
      '{1'b1, 5'd0, 32'd13, 8'd7,  8'd0}, '{1'b1, 5'd9, 32'd13, 8'd8,  8'd0},
      '{1'b1, 5'd9, 32'd21, 8'd9,  8'd0}, '{1'b1, 5'd9, 32'd34, 8'd10, 8'd0}
    };

    // Reset state
    idle(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_terms", 32'(term_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Nominal run, one hit every 5 cycles
    do_arm();
    chk("t1_busy_armed", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 5'd9, fib[i]);
      chk("t1_terms", 32'(term_count), 32'(i + 1));
      if (i < 9) idle(4);
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_timeout", 32'(timeout), 32'd0);
    chk("t1_mis", 32'(mismatch_count), 32'd0);
    chk("t1_last", last_data, 32'd34);
    chk("t1_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 5'd9, 32'd55);
    chk("t1_hold_terms", 32'(term_count), 32'd10);
    chk("t1_hold_last", last_data, 32'd34);

    // Single mismatch on the 4th term
    do_arm();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 5'd9, (i == 3) ? 32'd3 : fib[i]);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_mis", 32'(mismatch_count), 32'd1);
    chk("t2_bad_idx", 32'(first_bad_idx), 32'd3);
    chk("t2_bad_data", first_bad_data, 32'd3);
    chk("t2_terms", 32'(term_count), 32'd10);

    // Filtering, table driven
    do_arm();
    chk("t3_cleared_mis", 32'(mismatch_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, vf[i].en, vf[i].addr, vf[i].data);
      chk("t3_terms", 32'(term_count), 32'(vf[i].exp_terms));
      chk("t3_mis", 32'(mismatch_count), 32'(vf[i].exp_mis));
    end
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_pass", 32'(pass), 32'd1);

    // Timeout after 64 hit-free cycles
    do_arm();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd9, fib[i]);
    idle(63);
    chk("t4_not_yet_done", 32'(done), 32'd0);
    chk("t4_still_busy", 32'(busy), 32'd1);
    idle(1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_terms", 32'(term_count), 32'd3);

    // Async reset mid-run
    do_arm();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 5'd9, fib[i]);
    chk("t5_terms_pre", 32'(term_count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_terms", 32'(term_count), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_last", last_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd9, fib[i]);
    chk("t5_ignored_terms", 32'(term_count), 32'd0);
    chk("t5_ignored_busy", 32'(busy), 32'd0);
    // Arm wins over a simultaneous hit
    do_arm();
    cyc(1'b0, 1'b1, 5'd9, fib[0]);
    cyc(1'b1, 1'b1, 5'd9, 32'd1);
    chk("t5_rearm_terms", 32'(term_count), 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 5'd9, fib[i]);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_pass", 32'(pass), 32'd1);
    chk("t5_terms", 32'(term_count), 32'd10);

    // Wrap-around configuration and re-arm from DONE
    do_arm();
    cyc(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 5'd9, 32'd1);
    cyc(1'b0, 1'b1, 5'd9, 32'd0);
    cyc(1'b0, 1'b1, 5'd9, 32'd1);
    chk("t6_done", 32'(done2), 32'd1);
    chk("t6_pass", 32'(pass2), 32'd1);
    chk("t6_mis", 32'(mismatch_count2), 32'd0);
    do_arm();
    cyc(1'b0, 1'b1, 5'd9, 32'd5);
    chk("t6_busy", 32'(busy2), 32'd1);
    chk("t6_terms", 32'(term_count2), 32'd1);
    chk("t6_mis2", 32'(mismatch_count2), 32'd1);
    chk("t6_bad_idx", 32'(first_bad_idx2), 32'd0);
    chk("t6_bad_data", first_bad_data2, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_wb_checker.md
Name: fib_wb_checker

Overview:
- Synthesizable register-writeback checker that sits directly downstream of the MIPS register file write port inside `top`.
- Snoops every writeback and filters writes to one watched GPR, default $9, the Fibonacci result register.
- Compares each watched write against an internally generated Fibonacci sequence.
- Reports pass/fail, mismatch statistics and a no-progress timeout, so program correctness is checked in hardware instead of by eye from a `$monitor` trace.

Parameters:
- DATA_W, 32, width of writeback data and of the expected-value arithmetic.
- WATCH_REG, 9, GPR index to monitor; 0 is illegal and disables all checking.
- NUM_TERMS, 10, number of watched writes that completes a run (1..255).
- FIB0, 0, first expected term.
- FIB1, 1, second expected term.
- TIMEOUT_CYC, 64, max cycles allowed between watched writes while checking; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  one-cycle pulse: start or restart a check run.
- wb_en  input  1  register file write enable (RegWrite).
- wb_addr  input  5  register file write address.
- wb_data  input  DATA_W  register file write data.
- busy  output  1  high while in CHECK.
- done  output  1  high while in DONE.
- pass  output  1  valid when done: run completed with zero mismatches.
- timeout  output  1  valid when done: run ended by timeout.
- term_count  output  8  watched writes seen this run.
- mismatch_count  output  8  mismatching writes, saturates at 255.
- first_bad_idx  output  8  term index (0-based) of the first mismatch.
- first_bad_data  output  DATA_W  data of the first mismatching write.
- last_data  output  DATA_W  data of the most recent watched write.

Behaviour:
- Asynchronous reset (rst_n=0):
  - state=IDLE.
  - All outputs 0.
  - exp_a=FIB0, exp_b=FIB1.
  - idle_cnt=0.
- Watched write (hit): wb_en=1 and wb_addr==WATCH_REG and WATCH_REG!=0.
- IDLE:
  - Hits are ignored.
  - arm=1: go to CHECK next edge; clear all counters, flags, first_bad_* and last_data; reload exp_a/exp_b. A hit in the arm cycle is ignored.
- CHECK (busy=1):
  - On a hit:
    - Compare wb_data with exp_a.
    - term_count+1, last_data<=wb_data, idle_cnt<=0.
    - On mismatch: mismatch_count+1 (saturating). If mismatch_count was 0, capture first_bad_idx<=term_count (pre-increment) and first_bad_data<=wb_data.
    - Always advance: exp_a<=exp_b, exp_b<=exp_a+exp_b mod 2^DATA_W. There is no resync on mismatch.
  - No hit: idle_cnt+1.
  - Exit on term count: when the hit is the NUM_TERMS-th, go to DONE. On the following cycle done=1, and pass=1 iff the final mismatch_count (including that last compare) is 0.
  - Exit on timeout: if TIMEOUT_CYC!=0 and idle_cnt reaches TIMEOUT_CYC-1 on a non-hit cycle, go to DONE with timeout=1, pass=0. Timeout is flagged after exactly TIMEOUT_CYC consecutive hit-free cycles.
  - arm=1 in CHECK restarts the run as from IDLE; arm has priority over a simultaneous hit.
- DONE (done=1, busy=0):
  - All outputs hold; hits are ignored.
  - arm=1 re-arms into CHECK with a full clear.
- Latency: every status output is registered and updates on the edge after the causing cycle.
- rst_n asserted mid-run aborts immediately; no partial results are kept.

Test Plan:
1. Nominal run: arm, then 10 hits on reg 9 with data 0,1,1,2,3,5,8,13,21,34, one every 5 cycles -> one cycle after the 10th hit: done=1, pass=1, timeout=0, term_count=10, mismatch_count=0, last_data=34, busy=0.
2. Single mismatch: 4th hit carries 3 instead of 2, all others correct -> done=1, pass=0, mismatch_count=1, first_bad_idx=3, first_bad_data=3, term_count=10.
3. Filtering: interleave writes to reg 8 (data 99), reg 0, and reg 9 with wb_en=0 among correct hits -> only real hits counted; pass=1, term_count=10.
4. Timeout: 3 correct hits, then none -> done=1 and timeout=1 exactly 64 cycles after the 3rd hit; pass=0, term_count=3.
5. Async reset mid-run: after 5 hits, pulse rst_n low between clock edges -> outputs 0 immediately, not at the next edge. Subsequent hits are ignored until arm; a full 10-term run then passes.
6. Wrap and re-arm: FIB0=32'hFFFF_FFFF, FIB1=1, NUM_TERMS=4, hits FFFF_FFFF,1,0,1 -> pass=1. Arm in DONE, then hit 5 -> busy=1, term_count=1, mismatch_count=1, first_bad_idx=0.
